// File: rtl/and4_seq_reducer_pkg.sv
// Shared types and helpers for the time-multiplexed AND-reduction controller.
package and4_seq_reducer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of 4-bit slices needed to cover a WIDTH-bit operand.
  function automatic int unsigned nib_count(input int unsigned width);
    return (width + 32'd3) / 32'd4;
  endfunction

  // Fill value for operand bits above WIDTH; ones keep the AND neutral.
  localparam logic PAD_BIT = 1'b1;

  // AND4 input value while the unit is not in use.
  localparam logic [3:0] AND4_IDLE = 4'b1111;

endpackage

// File: rtl/and4_seq_reducer_if.sv
// Request/response bundle between a requester and the reducer.
interface and4_seq_reducer_if
  import and4_seq_reducer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
);
  localparam int unsigned NIB = nib_count(WIDTH);
  localparam int unsigned CW  = $clog2(NIB) + 1;

  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             busy;
  logic             done;
  logic             result;
  logic [CW-1:0]    cycles_used;

  modport master (
    output start, data_in,
    input  busy, done, result, cycles_used
  );

  modport slave (
    input  start, data_in,
    output busy, done, result, cycles_used
  );

endinterface

// File: rtl/and4_seq_reducer_multi_and4.sv
// Shared 4-input AND unit.
module multi_and4 (
  input  logic [3:0] a_i,
  output logic       y_o
);

  assign y_o = &a_i;

endmodule

// File: rtl/and4_seq_reducer.sv
// Wide AND reduction computed one nibble per cycle through a single AND4 unit.
module and4_seq_reducer
  import and4_seq_reducer_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          EARLY_EXIT = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  and4_seq_reducer_if.slave    bus
);

  localparam int unsigned NIB  = nib_count(WIDTH);
  localparam int unsigned SHW  = NIB * 4;
  localparam int unsigned IDXW = (NIB > 1) ? $clog2(NIB) : 1;
  localparam int unsigned CW   = $clog2(NIB) + 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIB - 1);

  state_e          state_q;
  logic [SHW-1:0]  shadow_q;
  logic [IDXW-1:0] idx_q;
  logic            acc_q;
  logic            busy_q;
  logic            done_q;
  logic            result_q;
  logic [CW-1:0]   cycles_q;

  logic [SHW-1:0]  cap_c;
  logic [3:0]      and_in_c;
  logic            p_c;
  logic            acc_next_c;
  logic            term_c;

  // Operand as stored: data_in in the low bits, ones above WIDTH.
  always_comb begin
    cap_c             = {SHW{PAD_BIT}};
    cap_c[WIDTH-1:0]  = bus.data_in;
  end

  // Feed the current nibble only in RUN; hold the gate inputs steady otherwise.
  always_comb begin
    and_in_c = AND4_IDLE;
    if (state_q == ST_RUN) begin
      and_in_c = shadow_q[{idx_q, 2'b00} +: 4];
    end
  end

  multi_and4 u_and4 (
    .a_i (and_in_c),
    .y_o (p_c)
  );

  // Running product and termination decision for the current RUN cycle.
  always_comb begin
    acc_next_c = acc_q & p_c;
    term_c     = (idx_q == LAST_IDX) || (EARLY_EXIT && !p_c);
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= {SHW{PAD_BIT}};
      idx_q    <= '0;
      acc_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      cycles_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shadow_q <= cap_c;
            idx_q    <= '0;
            acc_q    <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (term_c) begin
            result_q <= acc_next_c;
            cycles_q <= CW'(idx_q) + CW'(1);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end else begin
            acc_q <= acc_next_c;
            idx_q <= idx_q + IDXW'(1);
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.result      = result_q;
  assign bus.cycles_used = cycles_q;

endmodule

// File: tb/tb_and4_seq_reducer.sv
// Bench for and4_seq_reducer: three configurations driven in lockstep.
module tb_and4_seq_reducer;

  logic clk;
  logic rst;

  int total;
  int bad;

  // 0: WIDTH=16 early exit, 1: WIDTH=16 full scan, 2: WIDTH=10 early exit
  and4_seq_reducer_if #(.WIDTH(16)) if_e ();
  and4_seq_reducer_if #(.WIDTH(16)) if_f ();
  and4_seq_reducer_if #(.WIDTH(10)) if_w ();

  and4_seq_reducer #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_e (.clk(clk), .rst(rst), .bus(if_e));
  and4_seq_reducer #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_f (.clk(clk), .rst(rst), .bus(if_f));
  and4_seq_reducer #(.WIDTH(10), .EARLY_EXIT(1'b1)) u_w (.clk(clk), .rst(rst), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    bit r_e; int k_e;
    bit r_f; int k_f;
    bit r_w; int k_w;
  } vec_t;

  vec_t vecs[7];

  int ob_busy[3];
  int ob_done[3];
  int ob_done_c[3];
  int ob_res[3];
  int ob_cyc[3];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reduction computed straight from the operand bits.
  task automatic model(input int width, input bit early, input logic [15:0] d,
                       output bit r, output int k);
    int  nib;
    bit  found;
    nib   = (width + 3) / 4;
    r     = 1'b1;
    k     = nib;
    found = 1'b0;
    for (int j = 0; j < nib; j++) begin
      bit all1;
      all1 = 1'b1;
      for (int b = 0; b < 4; b++) begin
        if ((4 * j + b) < width && d[4 * j + b] == 1'b0) all1 = 1'b0;
      end
      if (!all1) begin
        r = 1'b0;
        if (early && !found) begin
          k     = j + 1;
          found = 1'b1;
        end
      end
    end
  endtask

  task automatic sample_all(input int c);
    logic [2:0] bz, dn, rs;
    int cy[3];
    bz = {if_w.busy, if_f.busy, if_e.busy};
    dn = {if_w.done, if_f.done, if_e.done};
    rs = {if_w.result, if_f.result, if_e.result};
    cy[0] = int'(if_e.cycles_used);
    cy[1] = int'(if_f.cycles_used);
    cy[2] = int'(if_w.cycles_used);
    for (int i = 0; i < 3; i++) begin
      if (bz[i]) ob_busy[i]++;
      if (dn[i]) begin
        if (ob_done[i] == 0) ob_done_c[i] = c;
        ob_done[i]++;
        ob_res[i] = int'(rs[i]);
        ob_cyc[i] = cy[i];
      end
    end
  endtask

  task automatic clear_obs();
    for (int i = 0; i < 3; i++) begin
      ob_busy[i] = 0; ob_done[i] = 0; ob_done_c[i] = -1;
      ob_res[i] = -1; ob_cyc[i] = -1;
    end
  endtask

  // One start pulse to all DUTs, then observe a fixed 8-cycle window.
  task automatic run_op(input logic [15:0] d);
    clear_obs();
    @(negedge clk);
    if_e.start = 1'b1; if_e.data_in = d;
    if_f.start = 1'b1; if_f.data_in = d;
    if_w.start = 1'b1; if_w.data_in = d[9:0];
    @(posedge clk);
    @(negedge clk);
    if_e.start = 1'b0; if_f.start = 1'b0; if_w.start = 1'b0;
    if_e.data_in = 16'h0; if_f.data_in = 16'h0; if_w.data_in = 10'h0;
    sample_all(0);
    for (int c = 1; c < 8; c++) begin
      @(negedge clk);
      sample_all(c);
    end
  endtask

  task automatic check_op(input string tag, input int i, input bit r, input int k);
    chk({tag, " busy_cycles"}, ob_busy[i], k);
    chk({tag, " done_count"}, ob_done[i], 1);
    chk({tag, " done_time"}, ob_done_c[i], k);
    chk({tag, " result"}, ob_res[i], int'(r));
    chk({tag, " cycles_used"}, ob_cyc[i], k);
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, " e.busy"}, int'(if_e.busy), 0);
    chk({tag, " e.done"}, int'(if_e.done), 0);
    chk({tag, " e.result"}, int'(if_e.result), 0);
    chk({tag, " e.cycles"}, int'(if_e.cycles_used), 0);
    chk({tag, " f.result"}, int'(if_f.result), 0);
    chk({tag, " f.cycles"}, int'(if_f.cycles_used), 0);
    chk({tag, " w.result"}, int'(if_w.result), 0);
    chk({tag, " w.cycles"}, int'(if_w.cycles_used), 0);
  endtask

  initial begin
    bit mr;
    int mk;
    logic [15:0] d;
    int dpos[$];

    total = 0;
    bad   = 0;
    clear_obs();

    vecs[0] = '{16'hFFFF, 1'b1, 4, 1'b1, 4, 1'b1, 3};
    vecs[1] = '{16'hFFEF, 1'b0, 2, 1'b0, 4, 1'b0, 2};
    vecs[2] = '{16'hFFF0, 1'b0, 1, 1'b0, 4, 1'b0, 1};
    vecs[3] = '{16'h7FFF, 1'b0, 4, 1'b0, 4, 1'b1, 3};
    vecs[4] = '{16'h03FF, 1'b0, 3, 1'b0, 4, 1'b1, 3};
    vecs[5] = '{16'h01FF, 1'b0, 3, 1'b0, 4, 1'b0, 3};
    vecs[6] = '{16'h0000, 1'b0, 1, 1'b0, 4, 1'b0, 1};

    rst = 1'b1;
    if_e.start = 1'b0; if_e.data_in = 16'h0;
    if_f.start = 1'b0; if_f.data_in = 16'h0;
    if_w.start = 1'b0; if_w.data_in = 10'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    rst = 1'b0;

    // Directed table
    for (int v = 0; v < 7; v++) begin
      run_op(vecs[v].d);
      check_op($sformatf("vec%0d e16", v), 0, vecs[v].r_e, vecs[v].k_e);
      check_op($sformatf("vec%0d f16", v), 1, vecs[v].r_f, vecs[v].k_f);
      check_op($sformatf("vec%0d w10", v), 2, vecs[v].r_w, vecs[v].k_w);
    end

    // Random operands, biased toward mostly-ones so late nibbles get exercised
    for (int n = 0; n < 40; n++) begin
      d = 16'($urandom);
      if (n % 2 == 0) d = d | 16'($urandom) | 16'($urandom);
      if (n % 5 == 0) d = 16'hFFFF & ~(16'h1 << $urandom_range(15, 0));
      run_op(d);
      model(16, 1'b1, d, mr, mk);
      check_op($sformatf("rnd%0d e16 d=%h", n, d), 0, mr, mk);
      model(16, 1'b0, d, mr, mk);
      check_op($sformatf("rnd%0d f16 d=%h", n, d), 1, mr, mk);
      model(10, 1'b1, d, mr, mk);
      check_op($sformatf("rnd%0d w10 d=%h", n, d), 2, mr, mk);
    end

    // Start held high: one operation per NIB+2 cycles
    clear_obs();
    @(negedge clk);
    if_e.start = 1'b1; if_e.data_in = 16'hFFFF;
    if_f.start = 1'b1; if_f.data_in = 16'hFFFF;
    if_w.start = 1'b1; if_w.data_in = 10'h3FF;
    @(posedge clk);
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (if_e.done) dpos.push_back(c);
      if (if_e.done && if_e.busy) chk("held busy_and_done", 1, 0);
      sample_all(c);
    end
    if_e.start = 1'b0; if_f.start = 1'b0; if_w.start = 1'b0;
    chk("held e16 done_count", ob_done[0], 5);
    chk("held e16 busy_cycles", ob_busy[0], 20);
    chk("held w10 done_count", ob_done[2], 6);
    chk("held w10 busy_cycles", ob_busy[2], 18);
    for (int i = 0; i < dpos.size(); i++) begin
      chk($sformatf("held e16 done_pos%0d", i), dpos[i], 4 + 6 * i);
    end
    repeat (8) @(negedge clk);

    // Reset during the second RUN cycle aborts without a done pulse
    run_op(16'hFFFF);
    check_op("pre_abort e16", 0, 1'b1, 4);
    clear_obs();
    @(negedge clk);
    if_e.start = 1'b1; if_e.data_in = 16'hFFFF;
    if_f.start = 1'b1; if_f.data_in = 16'hFFFF;
    if_w.start = 1'b1; if_w.data_in = 10'h3FF;
    @(posedge clk);
    @(negedge clk);
    if_e.start = 1'b0; if_f.start = 1'b0; if_w.start = 1'b0;
    chk("abort first_run busy", int'(if_e.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("abort");
    clear_obs();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      sample_all(c);
    end
    chk("abort e16 no_done", ob_done[0], 0);
    chk("abort w10 no_done", ob_done[2], 0);
    chk("abort e16 no_busy", ob_busy[0], 0);

    run_op(16'hFFEF);
    check_op("post_abort e16", 0, 1'b0, 2);
    check_op("post_abort f16", 1, 1'b0, 4);
    check_op("post_abort w10", 2, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
